// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO pointer blocks (read and write side).
//
//   Contents:
//     ADDR_W_DEF / PTR_W_DEF / DEPTH_DEF : default geometry (16 entries).
//     ptr_t      : pointer type for the default geometry, ADDR_W+1 bits wide
//                  (address plus wrap bit).
//     depth_of() : DEPTH = 2**ADDR_W derivation, used by every pointer block
//                  so the power-of-two rule lives in one place.
//     RD_LAT_MIN / RD_LAT_MAX : legal storage read latency range.
//     ADDR_W_MAX : largest address width the 32-bit helpers can carry.
//     bin2gray() : binary to reflected-Gray conversion, shared with the
//                  write-side block for async pointer crossing.
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Default geometry used by the standard 16-entry FIFO instances.
  localparam int ADDR_W_DEF = 4;
  localparam int PTR_W_DEF  = ADDR_W_DEF + 1;

  // Legal storage read latency, in cycles from fifo_rd to data.
  localparam int RD_LAT_MIN = 0;
  localparam int RD_LAT_MAX = 3;

  // The helpers below work on 32-bit values; a pointer (ADDR_W+1 bits) must
  // leave one spare bit so the zero-extended Gray MSB stays correct.
  localparam int ADDR_W_MAX = 30;

  // Number of storage entries for a given address width (power of two only).
  function automatic int depth_of(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);

  // Pointer with wrap bit for the default geometry.
  typedef logic [PTR_W_DEF-1:0] ptr_t;

  // Reflected binary Gray code: adjacent binary values differ in one bit.
  // Callers zero-extend narrower pointers and truncate the result back; the
  // zero upper bit makes the truncated MSB equal to the pointer MSB.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_lat_pipe.sv
// -----------------------------------------------------------------------------
// fifo_lat_pipe
//   Delay line that lines the read strobe up with data at the storage output.
//   LAT = 0 is a combinational pass-through; LAT = N > 0 is an N-deep shift
//   register, so back-to-back inputs give back-to-back outputs.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset, flushes every stage
//     din    in   strobe to delay (qualified read)
//     dout   out  din delayed by LAT cycles
// -----------------------------------------------------------------------------
module fifo_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (LAT == 0) begin : g_bypass
    // Clock and reset have no load in the zero-latency build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout           = din;
  end else begin : g_pipe
    logic [LAT-1:0] stage;

    // NOTE: every stage is reset, not just the output; a stale strobe left in
    // the middle of the line would surface as a false read-valid after reset.
    // NOTE: non-blocking assignments let each stage take its neighbour's
    // pre-edge value, which is what makes this a shift register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < LAT; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dout = stage[LAT-1];
  end

endmodule : fifo_lat_pipe

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//   Read-side controller for the dual-port FIFO storage. Owns the read
//   pointer (with wrap bit), derives empty / almost-empty / fill count from
//   the write pointer, qualifies client reads, records underflow attempts and
//   produces a read-data-valid strobe aligned to the storage read latency.
//
//   Parameters:
//     ADDR_W     address width, DEPTH = 2**ADDR_W entries
//     AE_THRESH  almost_empty when rd_count <= AE_THRESH (0..DEPTH-1)
//     RD_LAT     storage read latency in cycles (0..3)
//
//   Ports:
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     rd           in   client read request
//     wptr         in   write pointer incl. wrap bit, binary, same clock
//     clr_uflow    in   clears the sticky underflow flag
//     rptr         out  read pointer incl. wrap bit
//     raddr        out  storage read address (rptr without the wrap bit)
//     fifo_rd      out  qualified read, rd while not empty (combinational)
//     fifo_empty   out  rptr == wptr (combinational)
//     almost_empty out  rd_count <= AE_THRESH (combinational)
//     rd_count     out  entries held, wptr - rptr, 0..DEPTH (combinational)
//     rd_valid     out  read data valid at storage output
//     underflow    out  sticky: rd seen while empty
//     rptr_gray    out  registered Gray copy of rptr; only present when the
//                       macro FIFO_RPTR_GRAY_EN is defined
//
//   Build option:
//     FIFO_RPTR_GRAY_EN  adds the rptr_gray output for async-FIFO crossing.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AE_THRESH = 2,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic [ADDR_W:0]   wptr,
  input  logic              clr_uflow,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              fifo_rd,
  output logic              fifo_empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              rd_valid,
  output logic              underflow
`ifdef FIFO_RPTR_GRAY_EN
  ,
  output logic [ADDR_W:0]   rptr_gray
`endif
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = depth_of(ADDR_W);

  localparam logic [ADDR_W:0] PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W:0] AE_LIMIT = PTR_W'(AE_THRESH);

  // ---------------------------------------------------------------------------
  // Parameter legality, rejected at elaboration.
  // ---------------------------------------------------------------------------
  if (ADDR_W < 1 || ADDR_W > ADDR_W_MAX) begin : g_bad_addr_w
    $fatal(1, "fifo_rd_ctrl: ADDR_W=%0d outside 1..%0d", ADDR_W, ADDR_W_MAX);
  end

  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae_thresh
    $fatal(1, "fifo_rd_ctrl: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $fatal(1, "fifo_rd_ctrl: RD_LAT=%0d outside %0d..%0d", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
  end

  // ---------------------------------------------------------------------------
  // Status and read qualification.
  // Everything here is combinational from the registered rptr and the live
  // wptr. A write landing in the same cycle as rd is only seen once wptr
  // moves, so there is deliberately no write-to-read bypass.
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0] rptr_nxt;
  logic            uflow_attempt;

  // NOTE: each always_comb output gets a value on every path, so no latch can
  // be inferred.
  always_comb begin
    // Full-width compare: equal addresses with different wrap bits is full,
    // not empty.
    fifo_empty    = (rptr == wptr);
    // Modulo-2*DEPTH difference gives 0..DEPTH; the full case lands on DEPTH
    // through the wrap bit.
    rd_count      = wptr - rptr;
    almost_empty  = (rd_count <= AE_LIMIT);
    fifo_rd       = rd & ~fifo_empty;
    uflow_attempt = rd & fifo_empty;
    // The pointer naturally wraps 2*DEPTH-1 -> 0; the wrap bit toggles each
    // time the address part wraps DEPTH-1 -> 0.
    rptr_nxt      = fifo_rd ? (rptr + PTR_ONE) : rptr;
  end

  assign raddr = rptr[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Read pointer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
    end else begin
      rptr <= rptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky underflow. A new attempt on the same edge as a clear wins, so an
  // attempt is never lost between software reading the flag and clearing it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (uflow_attempt) begin
      underflow <= 1'b1;
    end else if (clr_uflow) begin
      underflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional Gray copy of the pointer. Converting the next binary value and
  // registering it keeps the output a clean flop with exactly one bit moving
  // per increment, which the far clock domain can synchronise safely.
  // ---------------------------------------------------------------------------
`ifdef FIFO_RPTR_GRAY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_gray <= '0;
    end else begin
      rptr_gray <= PTR_W'(bin2gray(32'(rptr_nxt)));
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read-data-valid strobe, delayed to match the storage read latency. Reset
  // flushes the line so no strobe from before reset can emerge afterwards.
  // ---------------------------------------------------------------------------
  fifo_lat_pipe #(
    .LAT (RD_LAT)
  ) u_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fifo_rd),
    .dout  (rd_valid)
  );

endmodule : fifo_rd_ctrl

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//   Self-checking bench for fifo_rd_ctrl (ADDR_W=4, AE_THRESH=2, RD_LAT=1).
//   A behavioural model (integer read index, fill count by modular
//   arithmetic, a per-cycle log of qualified reads) is compared against the
//   DUT on every falling edge; directed scenarios add hand-computed literal
//   expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  localparam int ADDR_W    = 4;
  localparam int AE_THRESH = 2;
  localparam int RD_LAT    = 1;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int PMOD      = 2 * DEPTH;
  localparam int LOG_LEN   = 8192;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              rd        = 1'b0;
  logic              clr_uflow = 1'b0;
  logic [ADDR_W:0]   wptr      = '0;

  logic [ADDR_W:0]   rptr;
  logic [ADDR_W-1:0] raddr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_count;
  logic              rd_valid;
  logic              underflow;
`ifdef FIFO_RPTR_GRAY_EN
  logic [ADDR_W:0]   rptr_gray;
  logic [ADDR_W:0]   prev_g;
`endif

  fifo_rd_ctrl #(
    .ADDR_W    (ADDR_W),
    .AE_THRESH (AE_THRESH),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd           (rd),
    .wptr         (wptr),
    .clr_uflow    (clr_uflow),
    .rptr         (rptr),
    .raddr        (raddr),
    .fifo_rd      (fifo_rd),
    .fifo_empty   (fifo_empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .rd_valid     (rd_valid),
    .underflow    (underflow)
`ifdef FIFO_RPTR_GRAY_EN
    ,
    .rptr_gray    (rptr_gray)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard counters and the single comparison primitive.
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the FIFO is an integer read index against the write
  // pointer; count is their modular distance; rd_valid is the qualified read
  // logged RD_LAT cycles earlier, with the log invalidated by reset.
  // ---------------------------------------------------------------------------
  int m_rptr  = 0;
  bit m_uflow = 1'b0;
  int cyc     = 0;
  int rst_cyc = 0;
  bit qlog [LOG_LEN];

  function automatic int m_count();
    return (int'(wptr) - m_rptr + PMOD) % PMOD;
  endfunction

  function automatic bit m_frd();
    return rd && (m_count() != 0);
  endfunction

  function automatic bit m_valid();
    int idx;
    if (RD_LAT == 0) return m_frd();
    idx = cyc - RD_LAT;
    if (idx < 0 || idx < rst_cyc) return 1'b0;
    return qlog[idx % LOG_LEN];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rptr  <= 0;
      m_uflow <= 1'b0;
    end else begin
      if (m_frd()) m_rptr <= (m_rptr + 1) % PMOD;
      if (rd && m_count() == 0) m_uflow <= 1'b1;
      else if (clr_uflow)       m_uflow <= 1'b0;
    end
  end

  always @(posedge clk) begin
    qlog[cyc % LOG_LEN] <= rst_n && m_frd();
    cyc                 <= cyc + 1;
  end

  always @(negedge rst_n) rst_cyc <= cyc;

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model, on the falling edge.
  // ---------------------------------------------------------------------------
  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_rptr",         rptr,         m_rptr);
      check("m_raddr",        raddr,        m_rptr % DEPTH);
      check("m_rd_count",     rd_count,     m_count());
      check("m_fifo_empty",   fifo_empty,   m_count() == 0);
      check("m_almost_empty", almost_empty, m_count() <= AE_THRESH);
      check("m_fifo_rd",      fifo_rd,      m_frd());
      check("m_rd_valid",     rd_valid,     m_valid());
      check("m_underflow",    underflow,    m_uflow);
`ifdef FIFO_RPTR_GRAY_EN
      check("m_rptr_gray",    rptr_gray,    m_rptr ^ (m_rptr >> 1));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge,
  // directed samples are taken on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Hand-computed drain sequence: wptr=3, rd held for 5 edges.
  int exp_r [5] = '{1, 2, 3, 3, 3};
  bit exp_v [5] = '{1, 1, 1, 0, 0};
  bit exp_u [5] = '{0, 0, 0, 1, 1};
  bit exp_e [5] = '{0, 0, 1, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rd        = 1'b0;
    wptr      = '0;
    clr_uflow = 1'b0;
    chk_on    = 1'b1;

    // Reset state with wptr=0.
    sample();
    check("rst_rptr",         rptr,         0);
    check("rst_fifo_empty",   fifo_empty,   1);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_rd_count",     rd_count,     0);
    check("rst_rd_valid",     rd_valid,     0);
    check("rst_underflow",    underflow,    0);
    tick();
    rst_n = 1'b1;
    sample();

    // Drain: three entries, five read cycles.
    tick();
    wptr = 5'd3;
    rd   = 1'b1;
    sample();
    check("drain_pre_count", rd_count,     3);
    check("drain_pre_ae",    almost_empty, 0);
    check("drain_pre_frd",   fifo_rd,      1);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 4) rd = 1'b0;
      sample();
      check("drain_rptr",      rptr,         exp_r[k]);
      check("drain_rd_valid",  rd_valid,     exp_v[k]);
      check("drain_underflow", underflow,    exp_u[k]);
      check("drain_empty",     fifo_empty,   exp_e[k]);
      check("drain_ae",        almost_empty, 1);
    end

    // Underflow clear race: set wins over clear on the same edge.
    clr_uflow = 1'b1;
    tick();
    rd = 1'b1;
    sample();
    check("race_cleared", underflow, 0);
    tick();
    rd = 1'b0;
    sample();
    check("race_set_wins", underflow, 1);
    tick();
    clr_uflow = 1'b0;
    sample();
    check("race_clear_alone", underflow, 0);

    // Reset mid-burst: rptr and rd_valid drop without a clock edge.
    tick();
    wptr = 5'd5;
    rd   = 1'b1;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_rptr",     rptr,     0);
    check("arst_rd_valid", rd_valid, 0);
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample();
    check("arst_rd_count", rd_count,   5);
    check("arst_empty",    fifo_empty, 0);
    check("arst_no_pulse", rd_valid,   0);

    // Full: rptr=0, wptr=16.
    tick();
    wptr = 5'd16;
    sample();
    check("full_rd_count", rd_count,     16);
    check("full_empty",    fifo_empty,   0);
    check("full_ae",       almost_empty, 0);

    // Wrap: walk rptr up to 31, then one more read wraps it to 0.
    tick();
    wptr = 5'd31;
    rd   = 1'b1;
`ifdef FIFO_RPTR_GRAY_EN
    prev_g = rptr_gray;
`endif
    for (int i = 0; i < 31; i++) begin
      tick();
      if (i == 30) rd = 1'b0;
      sample();
`ifdef FIFO_RPTR_GRAY_EN
      check("gray_step", $countones(rptr_gray ^ prev_g), 1);
      prev_g = rptr_gray;
`endif
    end
    check("wrap_rptr31",  rptr,       31);
    check("wrap_empty31", fifo_empty, 1);
`ifdef FIFO_RPTR_GRAY_EN
    check("wrap_gray31",  rptr_gray,  5'b10000);
`endif
    tick();
    wptr = 5'd0;
    rd   = 1'b1;
    tick();
    rd = 1'b0;
    sample();
    check("wrap_rptr0",  rptr,       0);
    check("wrap_empty0", fifo_empty, 1);
`ifdef FIFO_RPTR_GRAY_EN
    check("wrap_gray0",     rptr_gray, 0);
    check("gray_step_wrap", $countones(rptr_gray ^ prev_g), 1);
`endif

    // Randomized traffic with occasional clears and asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      tick();
      rd        = ($urandom_range(0, 9) < 7);
      clr_uflow = ($urandom_range(0, 19) == 0);
      if (m_count() < DEPTH && $urandom_range(0, 9) < (n < 750 ? 8 : 3))
        wptr = wptr + 1'b1;
      if ($urandom_range(0, 99) == 0) begin
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    sample();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_rd_ctrl
